fp_wb_collector: RTL and testbench
==================================

Name: fp_wb_collector

Overview:
- Consumer end of the FP intermediate-writeback handshake.
- Accepts pre-rounding results from several FP producer units (div, sqrt, fma, ...), each presenting done/id/payload and waiting for a same-cycle ack.
- Grants one producer per cycle using round-robin arbitration.
- Buffers accepted results in a 2-entry FIFO and presents them, in order, to the shared normalize/round stage with a valid/ready handshake.

Parameters:
- NUM_UNITS, 3, number of producer units; minimum 2.
- ID_W, 3, width of the instruction id tag.
- PAYLOAD_W, 128, packed intermediate result width (rd, fflags, rm, grs, clz, shift info, flags); opaque to this block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- unit_done  in  NUM_UNITS  producer i holds a result; held until acked.
- unit_id  in  NUM_UNITS*ID_W  id of producer i, slice [i*ID_W +: ID_W].
- unit_payload  in  NUM_UNITS*PAYLOAD_W  payload of producer i, slice [i*PAYLOAD_W +: PAYLOAD_W].
- unit_ack  out  NUM_UNITS  one-hot or zero; ack to producer i, same cycle as done.
- out_valid  out  1  FIFO head valid.
- out_id  out  ID_W  head id.
- out_payload  out  PAYLOAD_W  head payload.
- out_ready  in  1  downstream consumes head this cycle.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (rst low, asynchronous):
  - count=0, rr_ptr=0, head/tail pointers=0, all storage cleared.
  - out_valid=0, out_id=0, out_payload=0, occupancy=0.
  - unit_ack=0 while rst is low.
- Full: full = (registered count == 2). No same-cycle pop-bypass: a pop does not free space for a push in the same cycle.
- Arbitration (combinational):
  - When !full, grant the first i with unit_done[i]=1, searching from rr_ptr upward modulo NUM_UNITS.
  - unit_ack[grant]=1; all other ack bits 0.
  - When full or no done, unit_ack=0.
- rr_ptr update: on a grant at index g, rr_ptr <= (g+1) mod NUM_UNITS. Otherwise unchanged.
- Push: on a grant, write {unit_id[g], unit_payload[g]} at tail, tail <= tail^1.
- Pop: when out_valid & out_ready, head <= head^1.
  - out_ready with out_valid=0 is ignored.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle (possible only when count==1): count stays 1; the new entry becomes head next cycle.
- Outputs:
  - out_valid = (count != 0).
  - out_id/out_payload = storage[head], registered state only; no input-to-output combinational path.
- Latency:
  - A result acked in cycle t is visible on out_* in cycle t+1 when the FIFO was empty.
  - Otherwise it is visible after the entries ahead of it drain.
- Ordering: strict FIFO order of acceptance.
- Producer contract: a producer drops done the cycle after its ack; a producer not acked holds done/id/payload stable.
- Throughput: one accept and one deliver per cycle when out_ready is held high.
- Starvation freedom: any producer holding done is acked within NUM_UNITS grant cycles.
- Reset mid-operation: all buffered results are discarded and no ack is issued during reset. The first grant after release starts from unit 0.
- occupancy = count.

Test Plan:
- Reset with unit_done=3'b111, rst low -> unit_ack=0, out_valid=0, occupancy=0. Release rst -> cycle 0 acks unit0 (ack=3'b001); cycle 1 out_valid=1, out_id=unit0 id.
- All three units done continuously (ids 5,6,7), out_ready=1 -> acks in order 001,010,100,001 on consecutive cycles; out_id sequence 5,6,7 starting one cycle after the first ack.
- out_ready=0, unit1 done (id 2) and unit2 done (id 3) -> two acks, occupancy=2, then unit_ack=0 while unit0 done is pending. Pulse out_ready one cycle -> out_id 2 popped; the pop cycle still has ack=0; next cycle unit0 acked.
- count==1 (head id 4), out_ready=1 and unit2 done (id 1) in the same cycle -> ack=3'b100, occupancy stays 1, next cycle out_id=1.
- Unit0 done held, unit1 done pulsed every cycle, FIFO never full -> unit0 acked at least every 2 grant cycles (no starvation).
- Assert rst low while occupancy=2 -> out_valid=0 and occupancy=0 immediately (asynchronous). After release with no done inputs, outputs stay at 0.

Source files
------------

// File: rtl/fp_wb_collector.sv
// Purpose: collects FP pre-rounding results from several producers (round-robin ack) into a 2-entry FIFO.
// Latency: an accepted result appears on out_* the cycle after its ack if the FIFO was empty.
// Backpressure: out_ready low fills the FIFO; when full no producer is acked and done is held.
module fp_wb_collector #(
  parameter int NUM_UNITS = 3,
  parameter int ID_W      = 3,
  parameter int PAYLOAD_W = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_UNITS-1:0]           unit_done,
  input  logic [NUM_UNITS*ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS*PAYLOAD_W-1:0] unit_payload,
  output logic [NUM_UNITS-1:0]           unit_ack,
  output logic                           out_valid,
  output logic [ID_W-1:0]                out_id,
  output logic [PAYLOAD_W-1:0]           out_payload,
  input  logic                           out_ready,
  output logic [1:0]                     occupancy
);

  localparam int PTR_W = $clog2(NUM_UNITS);
  localparam int ENT_W = ID_W + PAYLOAD_W;

  logic [1:0]       count;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] rr_next;
  logic             grant_vld;
  logic             head;
  logic             tail;
  logic             full;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] mem [2];
  logic [ENT_W-1:0] push_dat;

  // A pop never frees space for a same-cycle push: full looks only at registered count.
  assign full = (count == 2'd2);

  // Round-robin search from rr_ptr upward; the ack is suppressed while full or in reset.
  always_comb begin : arb
    int               idx;
    logic [PTR_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      cand = PTR_W'(idx);
      if (!grant_vld && unit_done[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (full || !rst) grant_vld = 1'b0;
  end

  // One-hot ack to the granted producer, zero otherwise.
  always_comb begin
    unit_ack = '0;
    if (grant_vld) unit_ack[grant_idx] = 1'b1;
  end

  assign push     = grant_vld;
  assign pop      = out_valid & out_ready;
  assign rr_next  = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
  assign push_dat = {unit_id[grant_idx*ID_W +: ID_W], unit_payload[grant_idx*PAYLOAD_W +: PAYLOAD_W]};

  // FIFO storage, pointers, count and arbitration pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      rr_ptr <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_dat;
        tail      <= ~tail;
        rr_ptr    <= rr_next;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs come only from registered state.
  assign out_valid   = (count != 2'd0);
  assign out_id      = mem[head][ENT_W-1 -: ID_W];
  assign out_payload = mem[head][PAYLOAD_W-1:0];
  assign occupancy   = count;

endmodule

// File: tb/tb_fp_wb_collector.sv
// Bench for fp_wb_collector: a reference model predicts acks/occupancy, a scoreboard queue
// holds expected FIFO contents pushed on each predicted ack and popped on each delivery.
// Scenario-specific constant checks cover the directed cases.
module tb_fp_wb_collector;
  localparam int N  = 3;
  localparam int IW = 3;
  localparam int PW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    unit_done;
  logic [N*IW-1:0] unit_id;
  logic [N*PW-1:0] unit_payload;
  logic [N-1:0]    unit_ack;
  logic            out_valid;
  logic [IW-1:0]   out_id;
  logic [PW-1:0]   out_payload;
  logic            out_ready;
  logic [1:0]      occupancy;

  fp_wb_collector #(.NUM_UNITS(N), .ID_W(IW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id),
    .unit_payload(unit_payload), .unit_ack(unit_ack), .out_valid(out_valid),
    .out_id(out_id), .out_payload(out_payload), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [PW-1:0] pay;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  int   m_rr;
  int   m_cnt;

  // producer state driven by the bench
  logic [N-1:0]  pd;
  logic [N-1:0]  sticky;
  logic [IW-1:0] pid  [N];
  logic [PW-1:0] ppay [N];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    unit_done = pd;
    for (int i = 0; i < N; i++) begin
      unit_id[i*IW +: IW]      = pid[i];
      unit_payload[i*PW +: PW] = ppay[i];
    end
  endtask

  task automatic set_unit(input int u, input logic [IW-1:0] id, input logic stick);
    pd[u]     = 1'b1;
    sticky[u] = stick;
    pid[u]    = id;
    ppay[u]   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: drive, check at negedge against the model, advance the model after posedge.
  task automatic cycle(input logic rdy, output logic [N-1:0] ack_seen);
    logic [N-1:0] exp_ack;
    int           g;
    logic         pop;
    ent_t         e;
    out_ready = rdy;
    apply();
    @(negedge clk);
    exp_ack = '0;
    g = -1;
    if (m_cnt < 2) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && pd[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", 256'(unit_ack), 256'(exp_ack));
    check("occupancy", 256'(occupancy), 256'(m_cnt));
    check("out_valid", 256'(out_valid), 256'(m_cnt != 0));
    if (m_cnt != 0 && q.size() != 0)
      check("out_entry", 256'({out_id, out_payload}), 256'({q[0].id, q[0].pay}));
    pop      = rdy && (m_cnt != 0);
    ack_seen = unit_ack;
    @(posedge clk);
    #1;
    if (pop && q.size() != 0) void'(q.pop_front());
    if (g >= 0) begin
      e.id  = pid[g];
      e.pay = ppay[g];
      q.push_back(e);
      m_rr = (g + 1) % N;
      if (sticky[g]) ppay[g] = {$urandom, $urandom, $urandom, $urandom};
      else pd[g] = 1'b0;
    end
    m_cnt = q.size();
  endtask

  task automatic model_reset();
    q.delete();
    m_rr  = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    logic [N-1:0] a;
    pd = '0;
    for (int i = 0; i < 4 && m_cnt != 0; i++) cycle(1'b1, a);
    check("drained", 256'(m_cnt), 256'(0));
  endtask

  initial begin
    logic [N-1:0] a;
    int           gap;
    int           max_gap;
    rst       = 1'b0;
    out_ready = 1'b0;
    pd        = '0;
    sticky    = '0;
    for (int i = 0; i < N; i++) begin
      pid[i]  = '0;
      ppay[i] = '0;
    end
    apply();
    model_reset();

    // Reset with all producers done: no ack, empty FIFO
    set_unit(0, 3'd3, 1'b0);
    set_unit(1, 3'd4, 1'b0);
    set_unit(2, 3'd5, 1'b0);
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 256'(unit_ack), 256'(0));
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_occ", 256'(occupancy), 256'(0));
    check("rst_out_id", 256'(out_id), 256'(0));
    check("rst_out_payload", 256'(out_payload), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, a);
    check("first_ack_unit0", 256'(a), 256'(3'b001));
    check("first_out_valid", 256'(out_valid), 256'(1));
    check("first_out_id", 256'(out_id), 256'(3'd3));
    drain();

    // All three continuously done, out_ready high: rotating acks
    do_reset();
    set_unit(0, 3'd5, 1'b1);
    set_unit(1, 3'd6, 1'b1);
    set_unit(2, 3'd7, 1'b1);
    cycle(1'b1, a); check("rr_ack0", 256'(a), 256'(3'b001));
    cycle(1'b1, a); check("rr_ack1", 256'(a), 256'(3'b010));
    check("rr_id0", 256'(out_id), 256'(3'd6));
    cycle(1'b1, a); check("rr_ack2", 256'(a), 256'(3'b100));
    cycle(1'b1, a); check("rr_ack3", 256'(a), 256'(3'b001));
    sticky = '0;
    drain();

    // Full FIFO blocks acks; the pop cycle still does not ack
    do_reset();
    set_unit(1, 3'd2, 1'b0);
    set_unit(2, 3'd3, 1'b0);
    cycle(1'b0, a); check("full_ack1", 256'(a), 256'(3'b010));
    cycle(1'b0, a); check("full_ack2", 256'(a), 256'(3'b100));
    set_unit(0, 3'd6, 1'b0);
    cycle(1'b0, a); check("full_noack", 256'(a), 256'(0));
    check("full_occ", 256'(occupancy), 256'(2));
    check("full_head", 256'(out_id), 256'(3'd2));
    cycle(1'b1, a); check("pop_noack", 256'(a), 256'(0));
    check("after_pop_head", 256'(out_id), 256'(3'd3));
    cycle(1'b0, a); check("late_ack0", 256'(a), 256'(3'b001));
    drain();

    // Simultaneous push and pop at count==1
    do_reset();
    set_unit(0, 3'd4, 1'b0);
    cycle(1'b0, a); check("one_ack0", 256'(a), 256'(3'b001));
    set_unit(2, 3'd1, 1'b0);
    cycle(1'b1, a); check("pushpop_ack", 256'(a), 256'(3'b100));
    check("pushpop_occ", 256'(occupancy), 256'(1));
    check("pushpop_head", 256'(out_id), 256'(3'd1));
    drain();

    // Starvation: unit0 held, unit1 constantly done
    do_reset();
    set_unit(0, 3'd0, 1'b1);
    set_unit(1, 3'd1, 1'b1);
    gap     = 0;
    max_gap = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, a);
      gap++;
      if (a[0]) begin
        if (gap > max_gap) max_gap = gap;
        gap = 0;
      end
    end
    check("starve_gap", 256'(max_gap <= 2), 256'(1));
    sticky = '0;
    drain();

    // Asynchronous reset while full
    do_reset();
    set_unit(1, 3'd2, 1'b0);
    set_unit(2, 3'd3, 1'b0);
    cycle(1'b0, a);
    cycle(1'b0, a);
    check("pre_arst_occ", 256'(occupancy), 256'(2));
    set_unit(0, 3'd5, 1'b0);
    apply();
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 256'(out_valid), 256'(0));
    check("arst_occ", 256'(occupancy), 256'(0));
    check("arst_ack", 256'(unit_ack), 256'(0));
    model_reset();
    pd = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, a);
    check("post_arst_id", 256'(out_id), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
